adc_align_ctrl: RTL and testbench
=================================

# adc_align_ctrl

Per-channel word-alignment controller for the ADC capture path. It runs in the recovered `system_clk` domain of one `serdes_1_to_468_idelay_ddr` instance and watches that instance's deserialized frame-lane word. It drives single-cycle `bitslip` pulses until the frame word matches the expected training pattern, then monitors alignment and re-aligns on sustained loss. One instance is built per serdes channel, alongside `adc_capture_wrap`.

## Interface
- `W`, default 8: serdes factor and frame-word width.
- `PATTERN`, default 8'hF0: expected frame word when aligned.
- `SETTLE_CYC`, default 16: wait after lock or re-align before the first compare.
- `SLIP_WAIT`, default 4: dead cycles after each bitslip pulse, for serdes pipeline flush.
- `MATCH_N`, default 4: consecutive matches required to declare alignment.
- `MISS_N`, default 8: consecutive mismatches while aligned that trigger re-alignment.
- `MAX_SLIP`, default 2*W: slips allowed before declaring failure.

Ports:
- `system_clk` in 1: serdes system clock; the only clock.
- `system_rst_n` in 1: asynchronous, active-low reset.
- `rx_lckd` in 1: serdes lock, already synchronous to `system_clk`.
- `idelay_rdy` in 1: IDELAYCTRL ready; synchronized internally with a 2-flop synchronizer.
- `frame_word` in W: deserialized frame-lane word.
- `realign` in 1: single-cycle request to force re-alignment.
- `bitslip` out 1: bitslip pulse to the serdes.
- `aligned` out 1: high only in state ALIGNED.
- `align_fail` out 1: high only in state FAIL.
- `slip_cnt` out $clog2(MAX_SLIP+1): slips issued in the current attempt.
- `realign_cnt` out 8: re-alignments since reset; saturates at 255.
- `state_o` out 3: current state encoding, for debug.

## Operation
- States: IDLE=0, SETTLE=1, CHECK=2, SLIP=3, WAIT=4, ALIGNED=5, FAIL=6.
- Define `ok = rx_lckd && idelay_rdy_sync`. In any state, `!ok` moves to IDLE next cycle and clears `slip_cnt` and all counters. `realign_cnt` is not cleared.
- IDLE: when `ok`, go to SETTLE and load the wait counter with SETTLE_CYC-1.
- SETTLE: count down; at 0 go to CHECK with the match counter cleared.
- CHECK: compare the registered `frame_word` with PATTERN.
  - On a match, increment the match counter; on reaching MATCH_N go to ALIGNED.
  - On a mismatch, go to SLIP if `slip_cnt < MAX_SLIP`, otherwise go to FAIL.
- SLIP: `bitslip=1` for exactly this cycle. `slip_cnt++`. Go to WAIT with SLIP_WAIT-1 loaded.
- WAIT: count down; at 0 go to CHECK with the match counter cleared.
- ALIGNED:
  - A mismatch increments the miss counter; any match clears it.
  - On reaching MISS_N, go to SETTLE, clear `slip_cnt` and increment `realign_cnt`.
- FAIL: stay until `realign` or until `ok` drops.
- `realign` in any state other than IDLE: go to SETTLE, clear `slip_cnt`, increment `realign_cnt`. It takes priority over every other transition except `!ok`.
- Simultaneous match-count completion and `realign`: `realign` wins.

## Timing
- Reset values:
  - `bitslip=0`, `aligned=0`, `align_fail=0`
  - `slip_cnt=0`, `realign_cnt=0`
  - `state_o=0`
  - all internal counters 0; synchronizer flops 0.
- All outputs are registered.
- `frame_word` is registered once before compare, so compare latency is 1 cycle from input to decision.
- Minimum gap between two `bitslip` pulses is SLIP_WAIT + 2 cycles: SLIP, then SLIP_WAIT WAIT cycles, then at least 1 CHECK cycle.
- `idelay_rdy` synchronizer adds 2 cycles before `ok` rises.
- `aligned` rises on the cycle after the MATCH_N-th consecutive matching registered word.
- Reset asserted mid-slip: `bitslip` drops asynchronously.

## Structure
- Shared package `adc_capture_pkg` holds:
  - the `align_state_t` enum with the state encodings above;
  - the default PATTERN constant `FRAME_PATTERN_8B`.
- Sub-module `sync_2ff` is the generic 2-flop synchronizer for `idelay_rdy`, reusable elsewhere in capture.
- FSM, counters and compare stay in this module.

## Test plan
- **Aligned at start.** PATTERN=F0, feed F0 constantly, raise `ok`.
  - `bitslip` never pulses.
  - `aligned=1` at 2 + SETTLE_CYC + MATCH_N + 1 cycles after `rx_lckd`, counting the synchronizer.
  - `slip_cnt=0`.
- **Rotated by 3 slips.** Model rotates `frame_word` left by 1 per `bitslip`, starting at 1E.
  - Exactly 3 pulses, each ≥6 cycles apart.
  - `slip_cnt=3`, then `aligned=1`.
- **Never matches.** Feed 00.
  - 16 pulses are issued, then `align_fail=1` with `slip_cnt=16`.
  - No further pulses.
  - A `realign` pulse returns to SETTLE and increments `realign_cnt` to 1.
- **Miss threshold.** While aligned:
  - 7 mismatches, then a match: stays aligned.
  - 8 consecutive mismatches: `aligned` falls, `realign_cnt` increments, and re-alignment runs.
- **Lock loss.** Drop `rx_lckd` during WAIT: next cycle `state_o=0`, `slip_cnt=0`, no `bitslip`.
- **Async reset.** Assert `system_rst_n=0` during the SLIP cycle: `bitslip` falls immediately and all outputs take their reset values.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture path.
// Used by the alignment controller and capture wrappers.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CHECK   = 3'd2,
    ST_SLIP    = 3'd3,
    ST_WAIT    = 3'd4,
    ST_ALIGNED = 3'd5,
    ST_FAIL    = 3'd6
  } align_state_t;

  localparam logic [7:0] FRAME_PATTERN_8B = 8'hF0;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/adc_align_ctrl_sync_2ff.sv
// Generic two-flop synchronizer for single-bit
// level signals entering the capture clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/adc_align_ctrl.sv
// Frame-word alignment controller: bitslips the serdes
// until the frame lane shows PATTERN, then monitors lock.
module adc_align_ctrl
  import adc_capture_pkg::*;
#(
  parameter int             W          = 8,
  parameter logic [W-1:0]   PATTERN    = FRAME_PATTERN_8B,
  parameter int             SETTLE_CYC = 16,
  parameter int             SLIP_WAIT  = 4,
  parameter int             MATCH_N    = 4,
  parameter int             MISS_N     = 8,
  parameter int             MAX_SLIP   = 2 * W
) (
  input  logic                          system_clk,
  input  logic                          system_rst_n,
  input  logic                          rx_lckd,
  input  logic                          idelay_rdy,
  input  logic [W-1:0]                  frame_word,
  input  logic                          realign,
  output logic                          bitslip,
  output logic                          aligned,
  output logic                          align_fail,
  output logic [$clog2(MAX_SLIP+1)-1:0] slip_cnt,
  output logic [7:0]                    realign_cnt,
  output logic [2:0]                    state_o
);

  localparam int WMAX = (SETTLE_CYC > SLIP_WAIT)
                      ? SETTLE_CYC : SLIP_WAIT;
  localparam int WCW  = $clog2(WMAX + 1);
  localparam int SCW  = $clog2(MAX_SLIP + 1);
  localparam int MCW  = $clog2(MATCH_N + 1);
  localparam int NCW  = $clog2(MISS_N + 1);

  localparam logic [WCW-1:0] SETTLE_LD  = WCW'(SETTLE_CYC - 1);
  localparam logic [WCW-1:0] SLIP_LD    = WCW'(SLIP_WAIT - 1);
  localparam logic [SCW-1:0] SLIP_MAX   = SCW'(MAX_SLIP);
  localparam logic [MCW-1:0] MATCH_LAST = MCW'(MATCH_N - 1);
  localparam logic [NCW-1:0] MISS_LAST  = NCW'(MISS_N - 1);

  logic idelay_rdy_sync;
  logic ok;
  logic match;

  align_state_t   state_q,   state_d;
  logic [W-1:0]   frame_q,   frame_d;
  logic [WCW-1:0] wait_q,    wait_d;
  logic [MCW-1:0] match_q,   match_d;
  logic [NCW-1:0] miss_q,    miss_d;
  logic [SCW-1:0] slip_q,    slip_d;
  logic [7:0]     realign_q, realign_d;
  logic           bitslip_q, bitslip_d;
  logic           aligned_q, aligned_d;
  logic           fail_q,    fail_d;

  sync_2ff u_rdy_sync (
    .clk   (system_clk),
    .rst_n (system_rst_n),
    .d     (idelay_rdy),
    .q     (idelay_rdy_sync)
  );

  assign ok    = rx_lckd && idelay_rdy_sync;
  assign match = (frame_q == PATTERN);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_word;
    wait_d    = wait_q;
    match_d   = match_q;
    miss_d    = miss_q;
    slip_d    = slip_q;
    realign_d = realign_q;

    if (!ok) begin
      state_d = ST_IDLE;
      wait_d  = '0;
      match_d = '0;
      miss_d  = '0;
      slip_d  = '0;
    end else if (realign && state_q != ST_IDLE) begin
      state_d   = ST_SETTLE;
      wait_d    = SETTLE_LD;
      match_d   = '0;
      miss_d    = '0;
      slip_d    = '0;
      realign_d = sat_inc8(realign_q);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          wait_d  = SETTLE_LD;
        end
        ST_SETTLE, ST_WAIT: begin
          if (wait_q == '0) begin
            state_d = ST_CHECK;
            match_d = '0;
          end else begin
            wait_d = wait_q - WCW'(1);
          end
        end
        ST_CHECK: begin
          if (match) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_ALIGNED;
              miss_d  = '0;
            end else begin
              match_d = match_q + MCW'(1);
            end
          end else if (slip_q < SLIP_MAX) begin
            state_d = ST_SLIP;
          end else begin
            state_d = ST_FAIL;
          end
        end
        ST_SLIP: begin
          state_d = ST_WAIT;
          wait_d  = SLIP_LD;
          slip_d  = slip_q + SCW'(1);
        end
        ST_ALIGNED: begin
          if (match) begin
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            state_d   = ST_SETTLE;
            wait_d    = SETTLE_LD;
            match_d   = '0;
            miss_d    = '0;
            slip_d    = '0;
            realign_d = sat_inc8(realign_q);
          end else begin
            miss_d = miss_q + NCW'(1);
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // outputs follow the next state so they are flops, not decodes
    bitslip_d = (state_d == ST_SLIP);
    aligned_d = (state_d == ST_ALIGNED);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      wait_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      slip_q    <= '0;
      realign_q <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      wait_q    <= wait_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      slip_q    <= slip_d;
      realign_q <= realign_d;
      bitslip_q <= bitslip_d;
      aligned_q <= aligned_d;
      fail_q    <= fail_d;
    end
  end

  assign bitslip     = bitslip_q;
  assign aligned     = aligned_q;
  assign align_fail  = fail_q;
  assign slip_cnt    = slip_q;
  assign realign_cnt = realign_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Directed bench for adc_align_ctrl with a bitslip
// rotation model on the frame lane.
module tb_adc_align_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rx_lckd;
  logic       idelay_rdy;
  logic [7:0] frame_word;
  logic       realign;
  logic       bitslip;
  logic       aligned;
  logic       align_fail;
  logic [4:0] slip_cnt;
  logic [7:0] realign_cnt;
  logic [2:0] state_o;

  int checks;
  int failures;
  int cyc;
  int npulse;
  int last;
  int min_gap;
  bit rot_en;

  adc_align_ctrl dut (
    .system_clk   (clk),
    .system_rst_n (rst_n),
    .rx_lckd      (rx_lckd),
    .idelay_rdy   (idelay_rdy),
    .frame_word   (frame_word),
    .realign      (realign),
    .bitslip      (bitslip),
    .aligned      (aligned),
    .align_fail   (align_fail),
    .slip_cnt     (slip_cnt),
    .realign_cnt  (realign_cnt),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bitslip) begin
      if (npulse > 0 && (cyc - last) < min_gap)
        min_gap = cyc - last;
      last = cyc;
      npulse++;
      if (rot_en)
        frame_word = {frame_word[6:0], frame_word[7]};
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    rx_lckd    = 1'b0;
    idelay_rdy = 1'b0;
    realign    = 1'b0;
    frame_word = 8'h00;
    rot_en     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cyc     = 0;
    npulse  = 0;
    last    = 0;
    min_gap = 1000;
  endtask

  task automatic raise_ok();
    rx_lckd    = 1'b1;
    idelay_rdy = 1'b1;
  endtask

  task automatic wait_aligned(input string nm);
    int n;
    n = 0;
    while (!aligned && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (aligned !== 1'b1) begin
      failures++;
      $display("FAIL %s: aligned=%b required 1 (timeout)",
               nm, aligned);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_lckd = 1'b0;
    idelay_rdy = 1'b0;
    realign = 1'b0;
    frame_word = 8'h00;
    #1;
    checks++;
    if ({bitslip, aligned, align_fail} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b%b%b required 000",
               bitslip, aligned, align_fail);
    end
    checks++;
    if (slip_cnt !== 5'd0 || realign_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt: slip=%0d realign=%0d required 0 0",
               slip_cnt, realign_cnt);
    end
    checks++;
    if (state_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d required 0", state_o);
    end
  endtask

  task automatic test_aligned_start();
    do_reset();
    frame_word = 8'hF0;
    tick();
    cyc = 0;
    raise_ok();
    repeat (22) tick();
    checks++;
    if (aligned !== 1'b0) begin
      failures++;
      $display("FAIL start_early: aligned=%b at cyc %0d required 0",
               aligned, cyc);
    end
    tick();
    checks++;
    if (aligned !== 1'b1 || state_o !== 3'd5) begin
      failures++;
      $display("FAIL start_on_time: aligned=%b state=%0d required 1 5",
               aligned, state_o);
    end
    checks++;
    if (npulse != 0 || slip_cnt !== 5'd0) begin
      failures++;
      $display("FAIL start_no_slip: pulses=%0d slip=%0d required 0 0",
               npulse, slip_cnt);
    end
  endtask

  task automatic test_rotated();
    do_reset();
    frame_word = 8'h1E;
    rot_en = 1'b1;
    raise_ok();
    wait_aligned("rot_aligned");
    checks++;
    if (npulse != 3 || slip_cnt !== 5'd3) begin
      failures++;
      $display("FAIL rot_count: pulses=%0d slip=%0d required 3 3",
               npulse, slip_cnt);
    end
    checks++;
    if (min_gap < 6) begin
      failures++;
      $display("FAIL rot_gap: min gap %0d required >=6", min_gap);
    end
    checks++;
    if (frame_word !== 8'hF0) begin
      failures++;
      $display("FAIL rot_word: frame %h required f0", frame_word);
    end
  endtask

  task automatic test_never_match();
    int n;
    do_reset();
    frame_word = 8'h00;
    raise_ok();
    n = 0;
    while (!align_fail && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (align_fail !== 1'b1 || state_o !== 3'd6) begin
      failures++;
      $display("FAIL never_fail: fail=%b state=%0d required 1 6",
               align_fail, state_o);
    end
    checks++;
    if (npulse != 16 || slip_cnt !== 5'd16) begin
      failures++;
      $display("FAIL never_count: pulses=%0d slip=%0d required 16 16",
               npulse, slip_cnt);
    end
    repeat (20) tick();
    checks++;
    if (npulse != 16 || align_fail !== 1'b1) begin
      failures++;
      $display("FAIL never_hold: pulses=%0d fail=%b required 16 1",
               npulse, align_fail);
    end
    realign = 1'b1;
    tick();
    realign = 1'b0;
    checks++;
    if (state_o !== 3'd1 || realign_cnt !== 8'd1) begin
      failures++;
      $display("FAIL never_realign: state=%0d rcnt=%0d required 1 1",
               state_o, realign_cnt);
    end
    checks++;
    if (slip_cnt !== 5'd0 || align_fail !== 1'b0) begin
      failures++;
      $display("FAIL never_clear: slip=%0d fail=%b required 0 0",
               slip_cnt, align_fail);
    end
  endtask

  task automatic test_miss_threshold();
    int bad;
    do_reset();
    frame_word = 8'hF0;
    raise_ok();
    wait_aligned("miss_pre_aligned");
    frame_word = 8'h00;
    repeat (7) tick();
    frame_word = 8'hF0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (aligned !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || realign_cnt !== 8'd0) begin
      failures++;
      $display("FAIL miss7_hold: drops=%0d rcnt=%0d required 0 0",
               bad, realign_cnt);
    end
    frame_word = 8'h00;
    repeat (8) tick();
    checks++;
    if (aligned !== 1'b1) begin
      failures++;
      $display("FAIL miss8_early: aligned=%b required 1", aligned);
    end
    frame_word = 8'hF0;
    tick();
    checks++;
    if (aligned !== 1'b0 || state_o !== 3'd1 ||
        realign_cnt !== 8'd1) begin
      failures++;
      $display("FAIL miss8_drop: al=%b st=%0d rcnt=%0d required 0 1 1",
               aligned, state_o, realign_cnt);
    end
    wait_aligned("miss_realigned");
    checks++;
    if (realign_cnt !== 8'd1 || slip_cnt !== 5'd0) begin
      failures++;
      $display("FAIL miss_after: rcnt=%0d slip=%0d required 1 0",
               realign_cnt, slip_cnt);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    do_reset();
    frame_word = 8'h00;
    raise_ok();
    n = 0;
    while (state_o !== 3'd4 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (state_o !== 3'd4 || slip_cnt !== 5'd1) begin
      failures++;
      $display("FAIL lock_wait: state=%0d slip=%0d required 4 1",
               state_o, slip_cnt);
    end
    rx_lckd = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd0 || slip_cnt !== 5'd0 || bitslip !== 1'b0) begin
      failures++;
      $display("FAIL lock_drop: st=%0d slip=%0d bs=%b required 0 0 0",
               state_o, slip_cnt, bitslip);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    frame_word = 8'h00;
    raise_ok();
    repeat (3) tick();
    realign = 1'b1;
    tick();
    realign = 1'b0;
    checks++;
    if (realign_cnt !== 8'd1 || state_o !== 3'd1) begin
      failures++;
      $display("FAIL arst_pre: rcnt=%0d st=%0d required 1 1",
               realign_cnt, state_o);
    end
    n = 0;
    while (!bitslip && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bitslip !== 1'b1) begin
      failures++;
      $display("FAIL arst_slip: bitslip=%b required 1 (timeout)",
               bitslip);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bitslip, aligned, align_fail} !== 3'b000 ||
        slip_cnt !== 5'd0 || realign_cnt !== 8'd0 ||
        state_o !== 3'd0) begin
      failures++;
      $display("FAIL arst_vals: bs=%b al=%b f=%b s=%0d r=%0d st=%0d required all 0",
               bitslip, aligned, align_fail, slip_cnt,
               realign_cnt, state_o);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_aligned_start();
    test_rotated();
    test_never_match();
    test_miss_threshold();
    test_lock_loss();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
